// File: rtl/mp_pe_pkg.sv
// Shared definitions for the message-passing PE node: command codes,
// FSM state encodings and product-width helpers.
// Imported by mp_pipe_mult and mp_pe_node.
package mp_pe_pkg;

    localparam int PRECISION_DEF = 8;
    localparam int PROD_W        = 2 * PRECISION_DEF;

    typedef enum logic [3:0] {
        CMD_MAC         = 4'd0,
        CMD_SHIFT_UP    = 4'd1,
        CMD_SHIFT_DOWN  = 4'd2,
        CMD_SHIFT_LEFT  = 4'd3,
        CMD_SHIFT_RIGHT = 4'd4,
        CMD_LOAD_AB     = 4'd5,
        CMD_LOAD_S      = 4'd6,
        CMD_CLEAR       = 4'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic int prod_width(input int prec);
        return 2 * prec;
    endfunction

    // Shift commands occupy the contiguous code range up..right.
    function automatic logic is_shift(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd4);
    endfunction

endpackage

// File: rtl/mp_pipe_mult.sv
// Unsigned PRECISION x PRECISION multiplier with MUL_LAT register stages.
// Latency: MUL_LAT cycles from a/b to p; no handshake, free-running pipeline.
// Ports: CLK, a, b in; p out (2*PRECISION bits).
import mp_pe_pkg::*;

module mp_pipe_mult #(
    parameter int PRECISION = PRECISION_DEF,
    parameter int MUL_LAT   = 2
) (
    input  logic                       CLK,
    input  logic [PRECISION-1:0]       a,
    input  logic [PRECISION-1:0]       b,
    output logic [2*PRECISION-1:0]     p
);

    localparam int PW = prod_width(PRECISION);

    logic [PW-1:0] stage [MUL_LAT];

    // Pure datapath: the caller holds a/b stable for the whole MAC, so the
    // stages need no reset and no valid tracking.
    always_ff @(posedge CLK) begin
        stage[0] <= PW'(a) * PW'(b);
        for (int i = 1; i < MUL_LAT; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mp_pe_node.sv
// Systolic PE node: operand registers A/B, accumulator s_out with sticky ovf,
// multi-step neighbour shifts and pipelined MAC, driven by start/ready/done/ack.
// Ports: CLK/RST; command (start, cmd, count, image_to_shift, ack); status
// (ready, done); registers (A, B, s_out, ovf); neighbour in is*/out os*; direct loads.
import mp_pe_pkg::*;

module mp_pe_node #(
    parameter int PRECISION        = PRECISION_DEF,
    parameter int OUTPUT_PRECISION = 32,
    parameter int MUL_LAT          = 2,
    parameter int COUNT_W          = 4,
    parameter int SATURATE         = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic [3:0]                  cmd,
    input  logic [COUNT_W-1:0]          count,
    input  logic                        image_to_shift,
    input  logic                        ack,
    output logic                        ready,
    output logic                        done,
    output logic [PRECISION-1:0]        A,
    output logic [PRECISION-1:0]        B,
    output logic [OUTPUT_PRECISION-1:0] s_out,
    output logic                        ovf,
    input  logic [PRECISION-1:0]        isu,
    input  logic [PRECISION-1:0]        isd,
    input  logic [PRECISION-1:0]        isl,
    input  logic [PRECISION-1:0]        isr,
    output logic [PRECISION-1:0]        osu,
    output logic [PRECISION-1:0]        osd,
    output logic [PRECISION-1:0]        osl,
    output logic [PRECISION-1:0]        osr,
    input  logic [PRECISION-1:0]        a_overwrite,
    input  logic [PRECISION-1:0]        b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0] s_out_overwrite
);

    localparam int PW   = prod_width(PRECISION);
    localparam int SW   = OUTPUT_PRECISION + 1;
    localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e                 state;
    cmd_e                   cmd_q;
    logic                   img_q;
    logic [COUNT_W-1:0]     step_cnt;
    logic [MC_W-1:0]        mul_cnt;

    logic [PW-1:0]               prod;
    logic [SW-1:0]               sum;
    logic                        carry;
    logic [OUTPUT_PRECISION-1:0] acc_next;
    logic [PRECISION-1:0]        shift_in;
    logic [PRECISION-1:0]        tgt_old;

    mp_pipe_mult #(
        .PRECISION (PRECISION),
        .MUL_LAT   (MUL_LAT)
    ) u_mult (
        .CLK (CLK),
        .a   (A),
        .b   (B),
        .p   (prod)
    );

    always_comb begin
        // Extra top bit of the sum is the carry-out that feeds ovf.
        sum      = {1'b0, s_out} + SW'(prod);
        carry    = sum[OUTPUT_PRECISION];
        acc_next = sum[OUTPUT_PRECISION-1:0];
        if ((SATURATE != 0) && carry) begin
            acc_next = '1;
        end

        tgt_old = img_q ? B : A;

        case (cmd_q)
            CMD_SHIFT_DOWN:  shift_in = isd;
            CMD_SHIFT_LEFT:  shift_in = isl;
            CMD_SHIFT_RIGHT: shift_in = isr;
            default:         shift_in = isu;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            cmd_q    <= CMD_MAC;
            img_q    <= 1'b0;
            step_cnt <= '0;
            mul_cnt  <= '0;
            A        <= '0;
            B        <= '0;
            s_out    <= '0;
            ovf      <= 1'b0;
            osu      <= '0;
            osd      <= '0;
            osl      <= '0;
            osr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q    <= cmd_e'(cmd);
                        step_cnt <= count;
                        img_q    <= image_to_shift;
                        ready    <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (is_shift(cmd_q)) begin
                        // One step per edge; the old target value leaves
                        // through the output register of the same direction.
                        if (step_cnt != '0) begin
                            if (img_q) begin
                                B <= shift_in;
                            end else begin
                                A <= shift_in;
                            end
                            case (cmd_q)
                                CMD_SHIFT_UP:   osu <= tgt_old;
                                CMD_SHIFT_DOWN: osd <= tgt_old;
                                CMD_SHIFT_LEFT: osl <= tgt_old;
                                default:        osr <= tgt_old;
                            endcase
                            step_cnt <= step_cnt - COUNT_W'(1);
                        end
                        // count=0 finishes in one cycle without touching registers.
                        if (step_cnt <= COUNT_W'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else if (cmd_q == CMD_MAC) begin
                        // A/B have been stable since before accept, so the
                        // product is valid once the wait count expires.
                        mul_cnt <= MC_W'(MUL_LAT - 1);
                        state   <= ST_MUL_WAIT;
                    end else begin
                        case (cmd_q)
                            CMD_LOAD_AB: begin
                                A <= a_overwrite;
                                B <= b_overwrite;
                            end
                            CMD_LOAD_S: begin
                                s_out <= s_out_overwrite;
                            end
                            CMD_CLEAR: begin
                                A     <= '0;
                                B     <= '0;
                                s_out <= '0;
                                ovf   <= 1'b0;
                                osu   <= '0;
                                osd   <= '0;
                                osl   <= '0;
                                osr   <= '0;
                            end
                            default: begin
                            end
                        endcase
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end

                ST_MUL_WAIT: begin
                    if (mul_cnt == '0) begin
                        s_out <= acc_next;
                        ovf   <= ovf | carry;
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        mul_cnt <= mul_cnt - MC_W'(1);
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here, even with ack.
                    if (ack) begin
                        done  <= 1'b0;
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_pe_node.sv
module tb_mp_pe_node;

    localparam int P  = 8;
    localparam int OP = 32;
    localparam int ML = 2;
    localparam int CW = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           start = 1'b0;
    logic [3:0]     cmd = '0;
    logic [CW-1:0]  count = '0;
    logic           image_to_shift = 1'b0;
    logic           ack = 1'b0;
    logic [P-1:0]   isu = '0, isd = '0, isl = '0, isr = '0;
    logic [P-1:0]   a_ow = '0, b_ow = '0;
    logic [OP-1:0]  s_ow = '0;

    // SATURATE=1 instance
    logic           ready1, done1, ovf1;
    logic [P-1:0]   A1, B1, osu1, osd1, osl1, osr1;
    logic [OP-1:0]  s1;
    // SATURATE=0 instance
    logic           ready0, done0, ovf0;
    logic [P-1:0]   A0, B0, osu0, osd0, osl0, osr0;
    logic [OP-1:0]  s0;

    mp_pe_node #(.PRECISION(P), .OUTPUT_PRECISION(OP), .MUL_LAT(ML), .COUNT_W(CW), .SATURATE(1)) dut_sat (
        .CLK(CLK), .RST(RST), .start(start), .cmd(cmd), .count(count),
        .image_to_shift(image_to_shift), .ack(ack), .ready(ready1), .done(done1),
        .A(A1), .B(B1), .s_out(s1), .ovf(ovf1),
        .isu(isu), .isd(isd), .isl(isl), .isr(isr),
        .osu(osu1), .osd(osd1), .osl(osl1), .osr(osr1),
        .a_overwrite(a_ow), .b_overwrite(b_ow), .s_out_overwrite(s_ow)
    );

    mp_pe_node #(.PRECISION(P), .OUTPUT_PRECISION(OP), .MUL_LAT(ML), .COUNT_W(CW), .SATURATE(0)) dut_wrap (
        .CLK(CLK), .RST(RST), .start(start), .cmd(cmd), .count(count),
        .image_to_shift(image_to_shift), .ack(ack), .ready(ready0), .done(done0),
        .A(A0), .B(B0), .s_out(s0), .ovf(ovf0),
        .isu(isu), .isd(isd), .isl(isl), .isr(isr),
        .osu(osu0), .osd(osd0), .osl(osl0), .osr(osr0),
        .a_overwrite(a_ow), .b_overwrite(b_ow), .s_out_overwrite(s_ow)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the node, updated from the command rules.
    logic [P-1:0]  mA, mB;
    logic [P-1:0]  mos [4];
    logic [OP-1:0] mS1, mS0;
    logic          mO1, mO0;

    logic [P-1:0]  is_v [4];
    logic [P-1:0]  force_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mA = '0; mB = '0; mS1 = '0; mS0 = '0; mO1 = 1'b0; mO0 = 1'b0;
        for (int d = 0; d < 4; d++) mos[d] = '0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".A"},     64'(A1),   64'(mA));
        chk({tag, ".B"},     64'(B1),   64'(mB));
        chk({tag, ".s_sat"}, 64'(s1),   64'(mS1));
        chk({tag, ".s_wrp"}, 64'(s0),   64'(mS0));
        chk({tag, ".ovf_s"}, 64'(ovf1), 64'(mO1));
        chk({tag, ".ovf_w"}, 64'(ovf0), 64'(mO0));
        chk({tag, ".osu"},   64'(osu1), 64'(mos[0]));
        chk({tag, ".osd"},   64'(osd1), 64'(mos[1]));
        chk({tag, ".osl"},   64'(osl1), 64'(mos[2]));
        chk({tag, ".osr"},   64'(osr1), 64'(mos[3]));
    endtask

    task automatic set_is(input bit allow_force);
        logic [P-1:0] v;
        for (int d = 0; d < 4; d++) is_v[d] = P'($urandom);
        if (allow_force && force_q.size() != 0) begin
            v = force_q.pop_front();
            for (int d = 0; d < 4; d++) is_v[d] = v;
        end
        isu = is_v[0]; isd = is_v[1]; isl = is_v[2]; isr = is_v[3];
    endtask

    task automatic model_mac();
        logic [15:0] prod;
        logic [32:0] sum1, sum0;
        prod = 16'(mA) * 16'(mB);
        sum1 = 33'(mS1) + 33'(prod);
        if (sum1 > 33'h0_FFFF_FFFF) begin
            mS1 = 32'hFFFF_FFFF;
            mO1 = 1'b1;
        end else begin
            mS1 = sum1[31:0];
        end
        sum0 = 33'(mS0) + 33'(prod);
        if (sum0[32]) mO0 = 1'b1;
        mS0 = sum0[31:0];
    endtask

    // Issue one command, wait for done, check latency and state, then ack.
    // noise=1 pulses start/ack while busy and start while in DONE.
    task automatic run_cmd(input logic [3:0] c, input int n, input logic img,
                           input bit noise, output int lat);
        int exp_lat;
        chk("ready_idle", 64'(ready1), 64'd1);
        start = 1'b1; cmd = c; count = CW'(n); image_to_shift = img;
        set_is(1'b0);
        @(negedge CLK);
        start = 1'b0; cmd = 4'($urandom); count = CW'($urandom); image_to_shift = 1'($urandom);
        lat = 0;
        while (done1 !== 1'b1 && lat < 64) begin
            set_is(1'b1);
            if (noise) begin
                start = 1'b1; ack = 1'b1; cmd = 4'd7;
            end
            @(negedge CLK);
            lat++;
            start = 1'b0; ack = 1'b0;
            if (c >= 4'd1 && c <= 4'd4 && lat <= n) begin
                int d;
                logic [P-1:0] old;
                d   = int'(c) - 1;
                old = img ? mB : mA;
                if (img) mB = is_v[d]; else mA = is_v[d];
                mos[d] = old;
            end
        end
        case (c)
            4'd0: model_mac();
            4'd5: begin mA = a_ow; mB = b_ow; end
            4'd6: begin mS1 = s_ow; mS0 = s_ow; end
            4'd7: model_reset();
            default: ;
        endcase
        if (c == 4'd0)                   exp_lat = ML + 1;
        else if (c >= 4'd1 && c <= 4'd4) exp_lat = (n == 0) ? 1 : n;
        else                             exp_lat = 1;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_ready", 64'(ready1), 64'd0);
        chk_regs("cmd");
        if (noise) begin
            start = 1'b1; cmd = 4'd7;
            @(negedge CLK);
            start = 1'b0;
            chk("done_hold", 64'(done1), 64'd1);
            chk("done_hold.A", 64'(A1), 64'(mA));
        end
        ack = 1'b1;
        if (noise) begin start = 1'b1; cmd = 4'd7; end
        @(negedge CLK);
        ack = 1'b0; start = 1'b0;
        chk("ack.ready", 64'(ready1), 64'd1);
        chk("ack.done",  64'(done1),  64'd0);
    endtask

    initial begin
        int lat;

        // 1: reset for two cycles
        model_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst.ready", 64'(ready1), 64'd1);
        chk("rst.done",  64'(done1),  64'd0);
        chk_regs("rst");

        // 1b: reset in the middle of a 5-step shift
        start = 1'b1; cmd = 4'd1; count = CW'(5); image_to_shift = 1'b0;
        set_is(1'b0);
        @(negedge CLK);
        start = 1'b0;
        set_is(1'b0);
        repeat (2) @(negedge CLK);
        chk("midshift.busy", 64'(ready1), 64'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        chk("midrst.ready", 64'(ready1), 64'd1);
        chk("midrst.done",  64'(done1),  64'd0);
        chk_regs("midrst");

        // 2: single shift up into A
        force_q.push_back(8'h69);
        run_cmd(4'd1, 1, 1'b0, 1'b0, lat);
        chk("t2.A",   64'(A1),   64'h69);
        chk("t2.osu", 64'(osu1), 64'h00);

        // 3: three-step shift left into B
        force_q.push_back(8'h11); force_q.push_back(8'h22); force_q.push_back(8'h33);
        run_cmd(4'd3, 3, 1'b1, 1'b0, lat);
        chk("t3.B",   64'(B1),   64'h33);
        chk("t3.osl", 64'(osl1), 64'h22);
        chk("t3.lat", 64'(lat),  64'd3);

        // 4: load operands, two MACs
        a_ow = 8'h07; b_ow = 8'h86;
        run_cmd(4'd5, 0, 1'b0, 1'b0, lat);
        run_cmd(4'd0, 0, 1'b0, 1'b0, lat);
        chk("t4.s1",  64'(s1),  64'h3AA);
        chk("t4.lat", 64'(lat), 64'd3);
        run_cmd(4'd0, 0, 1'b0, 1'b0, lat);
        chk("t4.s2",  64'(s1),   64'h754);
        chk("t4.ovf", 64'(ovf1), 64'd0);

        // 5: overflow, saturating vs wrapping
        s_ow = 32'hFFFF_FFF0;
        run_cmd(4'd6, 0, 1'b0, 1'b0, lat);
        a_ow = 8'h10; b_ow = 8'h10;
        run_cmd(4'd5, 0, 1'b0, 1'b0, lat);
        run_cmd(4'd0, 0, 1'b0, 1'b0, lat);
        chk("t5.s_sat",   64'(s1),   64'hFFFF_FFFF);
        chk("t5.ovf_sat", 64'(ovf1), 64'd1);
        chk("t5.s_wrap",  64'(s0),   64'h0000_00F0);
        chk("t5.ovf_wrap",64'(ovf0), 64'd1);
        s_ow = 32'h0000_1234;
        run_cmd(4'd6, 0, 1'b0, 1'b0, lat);
        chk("t5.loads_keeps_ovf", 64'(ovf1), 64'd1);
        run_cmd(4'd7, 0, 1'b0, 1'b0, lat);
        chk("t5.clear_ovf", 64'(ovf1), 64'd0);

        // 6: stray start/ack, NOP code, zero-count shift
        a_ow = 8'h5A; b_ow = 8'hC3;
        run_cmd(4'd5, 0, 1'b0, 1'b1, lat);
        run_cmd(4'hB, 0, 1'b0, 1'b1, lat);
        chk("t6.nop_lat", 64'(lat), 64'd1);
        run_cmd(4'd2, 0, 1'b1, 1'b1, lat);
        chk("t6.cnt0_lat", 64'(lat), 64'd1);
        run_cmd(4'd0, 0, 1'b0, 1'b1, lat);

        // Random command stream against the model
        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            c    = 4'($urandom_range(0, 15));
            a_ow = P'($urandom);
            b_ow = P'($urandom);
            s_ow = ($urandom_range(0, 1) == 1) ? (32'hFFFF_0000 | 32'($urandom_range(0, 65535))) : 32'($urandom);
            run_cmd(c, $urandom_range(0, 15), 1'($urandom), 1'($urandom), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
